// File: rtl/anamux_pkg.sv
// rtl/anamux_pkg.sv - shared state type, channel constants and one-hot encoder for the analog mux sequencer
package anamux_pkg;

   localparam int ANAMUX_NUM_CH = 6;
   localparam int ANAMUX_CW     = 3;

   // All-ones index never names a real channel, so it doubles as "disconnect".
   localparam logic [ANAMUX_CW-1:0] CH_NONE = '1;

   typedef enum logic [1:0] {IDLE, BREAK, MAKE, HOLD} anamux_state_e;

   function automatic logic [ANAMUX_NUM_CH-1:0] onehot_enc(input logic [ANAMUX_CW-1:0] idx);
      logic [ANAMUX_NUM_CH-1:0] v;
      v = '0;
      for (int i = 0; i < ANAMUX_NUM_CH; i++) begin
         if (idx == i[ANAMUX_CW-1:0]) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/anamux_cycle_timer.sv
// rtl/anamux_cycle_timer.sv - loadable down-counter that parks at zero and flags done there
module anamux_cycle_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/anamux_switch_sequencer.sv
// rtl/anamux_switch_sequencer.sv - break-before-make switch sequencer for the analog mux
// Auto-scan with dwell timer is built only when ANAMUX_SCAN_EN is defined.
module anamux_switch_sequencer
   import anamux_pkg::*;
#(
   parameter int NUM_CH  = ANAMUX_NUM_CH,
   parameter int CW      = ANAMUX_CW,
   parameter int BBM_CYC = 4,
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [CW-1:0]      cmd_chan,
   input  logic               cmd_scan,
   input  logic [DWELL_W-1:0] dwell_len,
   input  logic               stop,
   output logic [NUM_CH-1:0]  mux_sel,
   output logic [CW-1:0]      cur_chan,
   output logic               ch_stable,
   output logic               busy
);

   localparam int BBM_W = (BBM_CYC > 1) ? $clog2(BBM_CYC) : 1;

   anamux_state_e       state_q, state_d;
   logic [CW-1:0]       target_q, target_d;
   logic                scanning_q, scanning_d;
   logic [NUM_CH-1:0]   mux_sel_q, mux_sel_d;
   logic [CW-1:0]       cur_chan_q, cur_chan_d;
   logic                ch_stable_q, ch_stable_d;
   logic                busy_q, busy_d;

   logic                accept, scan_req;
   logic                bbm_load, bbm_done;
   logic                dwell_load, dwell_done;
   logic [CW-1:0]       next_chan;

   assign cmd_ready = (state_q == IDLE) || ((state_q == HOLD) && !scanning_q);
   // stop wins over a same-cycle command even though cmd_ready is high.
   assign accept    = cmd_valid && cmd_ready && !stop;
   assign next_chan = (cur_chan_q == CW'(NUM_CH - 1)) ? '0 : cur_chan_q + 1'b1;

   anamux_cycle_timer #(.W(BBM_W)) u_bbm_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (bbm_load),
      .load_val (BBM_W'(BBM_CYC - 1)),
      .done     (bbm_done)
   );

`ifdef ANAMUX_SCAN_EN
   logic [DWELL_W-1:0] dwell_q, dwell_d;

   assign scan_req = cmd_scan;

   always_comb begin
      dwell_d = dwell_q;
      if (accept) dwell_d = (dwell_len == '0) ? DWELL_W'(1) : dwell_len;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dwell_q <= DWELL_W'(1);
      else        dwell_q <= dwell_d;
   end

   anamux_cycle_timer #(.W(DWELL_W)) u_dwell_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (dwell_load),
      .load_val (dwell_q - 1'b1),
      .done     (dwell_done)
   );
`else
   logic unused_scan;
   assign scan_req    = 1'b0;
   assign dwell_done  = 1'b0;
   assign unused_scan = ^{cmd_scan, dwell_len, dwell_load};
`endif

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      scanning_d = scanning_q;
      mux_sel_d  = mux_sel_q;
      cur_chan_d = cur_chan_q;
      bbm_load   = 1'b0;
      dwell_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d    = BREAK;
               target_d   = cmd_chan;
               scanning_d = scan_req;
               bbm_load   = 1'b1;
            end
         end
         BREAK: begin
            if (stop) target_d = CH_NONE;
            if (bbm_done) begin
               state_d = (stop || int'(target_q) >= NUM_CH) ? IDLE : MAKE;
            end
         end
         MAKE: begin
            if (stop) begin
               state_d  = BREAK;
               target_d = CH_NONE;
               bbm_load = 1'b1;
            end else begin
               state_d    = HOLD;
               mux_sel_d  = onehot_enc(target_q);
               cur_chan_d = target_q;
               dwell_load = 1'b1;
            end
         end
         HOLD: begin
            if (stop) begin
               state_d    = BREAK;
               target_d   = CH_NONE;
               scanning_d = 1'b0;
               bbm_load   = 1'b1;
            end else if (accept) begin
               state_d    = BREAK;
               target_d   = cmd_chan;
               scanning_d = scan_req;
               bbm_load   = 1'b1;
            end else if (scanning_q && dwell_done) begin
               state_d  = BREAK;
               target_d = next_chan;
               bbm_load = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Opening the switches rides the same edge that leaves HOLD/MAKE.
      if (state_d == BREAK || state_d == IDLE) mux_sel_d = '0;
      if (state_d == IDLE) scanning_d = 1'b0;
      ch_stable_d = (state_q == HOLD) && (state_d == HOLD);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         target_q    <= CH_NONE;
         scanning_q  <= 1'b0;
         mux_sel_q   <= '0;
         cur_chan_q  <= '0;
         ch_stable_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         scanning_q  <= scanning_d;
         mux_sel_q   <= mux_sel_d;
         cur_chan_q  <= cur_chan_d;
         ch_stable_q <= ch_stable_d;
         busy_q      <= busy_d;
      end
   end

   assign mux_sel   = mux_sel_q;
   assign cur_chan  = cur_chan_q;
   assign ch_stable = ch_stable_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_anamux_switch_sequencer.sv
// tb/tb_anamux_switch_sequencer.sv - randomized and directed bench for anamux_switch_sequencer against a timeline model
module tb_anamux_switch_sequencer;

   localparam int NUM_CH  = 6;
   localparam int CW      = 3;
   localparam int BBM     = 4;
   localparam int DWELL_W = 8;
`ifdef ANAMUX_SCAN_EN
   localparam bit SCAN = 1'b1;
`else
   localparam bit SCAN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               cmd_valid = 1'b0;
   logic [CW-1:0]      cmd_chan = '0;
   logic               cmd_scan = 1'b0;
   logic [DWELL_W-1:0] dwell_len = '0;
   logic               stop = 1'b0;
   logic               cmd_ready;
   logic [NUM_CH-1:0]  mux_sel;
   logic [CW-1:0]      cur_chan;
   logic               ch_stable;
   logic               busy;

   int tests = 0;
   int fails = 0;

   // Timeline model: times are absolute edge numbers since reset.
   int  m_n = 0;
   bit  m_act = 1'b0;
   bit  m_scn = 1'b0;
   int  m_brk_at = 0;
   int  m_conn_at = -1;
   int  m_tgt = -1;
   int  m_cur = 0;
   int  m_dw = 1;
   bit  m_rdy, m_acc, m_brk;
   int  m_nt;
   logic [NUM_CH-1:0] prev_sel = '0;

   anamux_switch_sequencer #(.NUM_CH(NUM_CH), .CW(CW), .BBM_CYC(BBM), .DWELL_W(DWELL_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_chan  (cmd_chan),
      .cmd_scan  (cmd_scan),
      .dwell_len (dwell_len),
      .stop      (stop),
      .mux_sel   (mux_sel),
      .cur_chan  (cur_chan),
      .ch_stable (ch_stable),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_sel();
      return (m_act && m_conn_at >= 0) ? (32'd1 << m_cur) : 32'd0;
   endfunction

   function automatic logic [31:0] exp_stable();
      return 32'(m_act && m_conn_at >= 0 && m_n > m_conn_at);
   endfunction

   function automatic logic [31:0] exp_ready();
      return 32'(!m_act || (m_conn_at >= 0 && !m_scn));
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_n = 0; m_act = 1'b0; m_scn = 1'b0; m_brk_at = 0;
         m_conn_at = -1; m_tgt = -1; m_cur = 0; m_dw = 1;
      end else begin
         m_n++;
         m_rdy = !m_act || (m_conn_at >= 0 && !m_scn);
         m_acc = cmd_valid && m_rdy && !stop;
         m_brk = 1'b0;
         m_nt  = -1;
         if (!m_act || m_conn_at >= 0) begin
            if (m_act && stop) begin
               m_brk = 1'b1; m_scn = 1'b0;
            end else if (m_acc) begin
               m_brk = 1'b1; m_nt = int'(cmd_chan);
               m_scn = SCAN && cmd_scan;
               m_dw  = (dwell_len == '0) ? 1 : int'(dwell_len);
            end else if (m_act && m_scn && (m_n - m_conn_at == m_dw)) begin
               m_brk = 1'b1; m_nt = (m_cur == NUM_CH - 1) ? 0 : m_cur + 1;
            end
         end else if (m_n - m_brk_at <= BBM) begin
            if (stop) m_tgt = -1;
            if (m_n - m_brk_at == BBM && (m_tgt < 0 || m_tgt >= NUM_CH)) begin
               m_act = 1'b0; m_scn = 1'b0;
            end
         end else begin
            if (stop) begin
               m_brk = 1'b1; m_scn = 1'b0;
            end else begin
               m_conn_at = m_n; m_cur = m_tgt;
            end
         end
         if (m_brk) begin
            m_act = 1'b1; m_brk_at = m_n; m_conn_at = -1; m_tgt = m_nt;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      check("mux_sel", 32'(mux_sel), exp_sel());
      check("cur_chan", 32'(cur_chan), 32'(m_cur));
      check("ch_stable", 32'(ch_stable), exp_stable());
      check("busy", 32'(busy), 32'(m_act));
      check("cmd_ready", 32'(cmd_ready), exp_ready());
      check("onehot0", 32'($onehot0(mux_sel)), 32'd1);
      check("no_direct_switch", 32'(prev_sel != '0 && mux_sel != '0 && prev_sel != mux_sel), 32'd0);
      prev_sel = mux_sel;
   end

   task automatic cmd(input int ch, input bit scan, input int dw);
      cmd_valid = 1'b1;
      cmd_chan  = CW'(ch);
      cmd_scan  = scan;
      dwell_len = DWELL_W'(dw);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_scan  = 1'b0;
   endtask

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   initial begin
      int p;
      logic [31:0] e;
      cyc(2);
      check("rst_mux_sel", 32'(mux_sel), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      rst_n = 1'b1;
      cyc(1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cur", 32'(cur_chan), 32'd0);

      cmd(2, 1'b0, 0);
      check("t1_busy_e0", 32'(busy), 32'd1);
      check("t1_ready_e0", 32'(cmd_ready), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         cyc(1);
         check("t1_open", 32'(mux_sel), 32'd0);
      end
      cyc(1);
      check("t1_make_e5", 32'(mux_sel), 32'b000100);
      check("t1_unstable_e5", 32'(ch_stable), 32'd0);
      cyc(1);
      check("t1_stable_e6", 32'(ch_stable), 32'd1);
      check("t1_cur", 32'(cur_chan), 32'd2);

      cmd(5, 1'b0, 0);
      check("t2_drop_mux", 32'(mux_sel), 32'd0);
      check("t2_drop_stable", 32'(ch_stable), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         cyc(1);
         check("t2_open", 32'(mux_sel), 32'd0);
      end
      cyc(1);
      check("t2_make", 32'(mux_sel), 32'b100000);

      cmd(3, 1'b0, 0);
      cyc(6);
      cmd(7, 1'b0, 0);
      cyc(3);
      check("t3_busy_break", 32'(busy), 32'd1);
      cyc(1);
      check("t3_busy_fall", 32'(busy), 32'd0);
      check("t3_mux", 32'(mux_sel), 32'd0);
      check("t3_cur_kept", 32'(cur_chan), 32'd3);
      check("t3_ready", 32'(cmd_ready), 32'd1);

`ifdef ANAMUX_SCAN_EN
      cmd(4, 1'b1, 3);
      for (int k = 0; k <= 31; k++) begin
         if (k > 0) cyc(1);
         p = k - (BBM + 1);
         e = (p >= 0 && (p % 8) < 3) ? (32'd1 << ((4 + p / 8) % NUM_CH)) : 32'd0;
         check("t4_scan_seq", 32'(mux_sel), e);
         check("t4_ready_low", 32'(cmd_ready), 32'd0);
      end
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      cyc(6);
`endif

      cmd(1, 1'b0, 0);
      cyc(6);
      stop = 1'b1;
      cmd(3, 1'b0, 0);
      stop = 1'b0;
      check("t5_mux_open", 32'(mux_sel), 32'd0);
      check("t5_busy", 32'(busy), 32'd1);
      cyc(4);
      check("t5_idle", 32'(busy), 32'd0);
      cyc(2);
      check("t5_no_accept_cur", 32'(cur_chan), 32'd1);
      check("t5_mux_zero", 32'(mux_sel), 32'd0);

      cmd(4, 1'b0, 0);
      cyc(7);
      check("t6_held", 32'(mux_sel), 32'b010000);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_mux", 32'(mux_sel), 32'd0);
      check("t6_async_stable", 32'(ch_stable), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cmd(0, 1'b0, 0);
      cyc(5);
      check("t6_restart", 32'(mux_sel), 32'b000001);
      cyc(1);
      check("t6_restart_stable", 32'(ch_stable), 32'd1);

      for (int i = 0; i < 4000; i++) begin
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_chan  = CW'($urandom_range(0, 7));
         cmd_scan  = 1'($urandom_range(0, 1));
         dwell_len = DWELL_W'($urandom_range(0, 4));
         stop      = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 799) == 0) begin
            #2 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      stop = 1'b0;
      cyc(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
